// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and memory write port of the program loader.
// Ports: in_data/in_valid/in_ready stream handshake, mem_wEn/mem_addr/mem_dataOut write port.
interface imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_wEn;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_dataOut;

    // master: the loader (consumes bytes, drives the write port)
    modport master (
        input  in_data, in_valid,
        output in_ready, mem_wEn, mem_addr, mem_dataOut
    );

    // slave: the environment (byte source, memory)
    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_wEn, mem_addr, mem_dataOut
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader writing 32-bit words into instruction/data memory.
// Ports: clock, reset (async, high), bus (imem_loader_if.master), reload,
//        cpu_reset (processor held while loading), done, error.
// Frame: 16-bit big-endian word count N, then N big-endian words.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic  clock,
    input  logic  reset,
    imem_loader_if.master bus,
    input  logic  reload,
    output logic  cpu_reset,
    output logic  done,
    output logic  error
);

    localparam logic [2:0] HDR_HI = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CSUM   = 3'd3;
`endif
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    // state entered after the last payload word (or an empty image)
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] END_ST = CSUM;
`else
    localparam logic [2:0] END_ST = DONE;
`endif

    // largest word count that fits above BASE_ADDR without wrapping
    localparam logic [32:0] LIMIT =
        33'((33'd1 << ADDR_W) - 33'(BASE_ADDR));

    logic [2:0]        state;
    logic [15:0]       cnt;
    logic [ADDR_W:0]   wcnt;
    logic [1:0]        idx;
    logic [23:0]       asm_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic        acc;
    logic [15:0] n_in;

    assign bus.in_ready = ~reset & (state != DONE) & (state != ERR);
    assign acc          = bus.in_valid & bus.in_ready;
    assign n_in         = {cnt[15:8], bus.in_data};
    assign done         = (state == DONE);
    assign error        = (state == ERR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= HDR_HI;
            cpu_reset       <= 1'b1;
            cnt             <= '0;
            wcnt            <= '0;
            idx             <= '0;
            asm_q           <= '0;
            bus.mem_wEn     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_dataOut <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum            <= '0;
`endif
        end else begin
            bus.mem_wEn <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (acc) begin
                        cnt[15:8] <= bus.in_data;
                        state     <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (acc) begin
                        cnt[7:0] <= bus.in_data;
                        if (33'(n_in) > LIMIT) begin
                            state <= ERR;
                        end else if (n_in == 16'd0) begin
                            state <= END_ST;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (acc) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.in_data;
`endif
                        idx   <= idx + 2'd1;
                        asm_q <= {asm_q[15:0], bus.in_data};
                        if (idx == 2'd3) begin
                            bus.mem_wEn     <= 1'b1;
                            bus.mem_addr    <= ADDR_W'(BASE_ADDR)
                                             + wcnt[ADDR_W-1:0];
                            bus.mem_dataOut <= {asm_q, bus.in_data};
                            wcnt            <= wcnt + 1'b1;
                            if (32'(wcnt) + 32'd1 == 32'(cnt)) begin
                                state <= END_ST;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (acc) begin
                        state <= (bus.in_data == csum) ? DONE : ERR;
                    end
                end
`endif
                DONE: begin
                    // released one edge after DONE so the last write lands first
                    cpu_reset <= 1'b0;
                    if (reload) begin
                        state     <= HDR_HI;
                        cpu_reset <= 1'b1;
                        cnt       <= '0;
                        wcnt      <= '0;
                        idx       <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                ERR: begin
                    if (reload) begin
                        state     <= HDR_HI;
                        cpu_reset <= 1'b1;
                        cnt       <= '0;
                        wcnt      <= '0;
                        idx       <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Drives framed byte streams and checks writes, status and cpu_reset timing.
module tb_imem_loader;

    logic clock;
    logic reset;
    logic reload;
    logic cpu_reset;
    logic done;
    logic error;

    int total;
    int bad;
    int wcount;
    logic [11:0] q_addr[$];
    logic [31:0] q_data[$];

    imem_loader_if #(.ADDR_W(12)) bus ();

    imem_loader #(
        .ADDR_W(12),
        .BASE_ADDR(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .reload(reload),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // write log, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.mem_wEn === 1'b1) begin
            wcount++;
            q_addr.push_back(bus.mem_addr);
            q_data.push_back(bus.mem_dataOut);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // optional idle cycle, then one byte accepted at the next edge
    task automatic put(input logic [7:0] b, input logic gap);
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick();
    endtask

    task automatic clr_log();
        wcount = 0;
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic do_reload();
        bus.in_valid = 1'b0;
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        wcount = 0;
        reset = 1'b1;
        reload = 1'b0;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;

        // reset state
        #3;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wen", bus.mem_wEn, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_data", bus.mem_dataOut, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("hdr_in_ready", bus.in_ready, 1);

        // N=2, continuous valid
        put(8'h00, 0);
        put(8'h02, 0);
        put(8'hDE, 0);
        put(8'hAD, 0);
        put(8'hBE, 0);
        chk("t1_no_early_wen", bus.mem_wEn, 0);
        put(8'hEF, 0);
        chk("t1_w0_wen", bus.mem_wEn, 1);
        chk("t1_w0_addr", bus.mem_addr, 0);
        chk("t1_w0_data", bus.mem_dataOut, 32'hDEADBEEF);
        put(8'h01, 0);
        chk("t1_wen_single", bus.mem_wEn, 0);
        put(8'h23, 0);
        put(8'h45, 0);
        put(8'h67, 0);
        chk("t1_w1_wen", bus.mem_wEn, 1);
        chk("t1_w1_addr", bus.mem_addr, 1);
        chk("t1_w1_data", bus.mem_dataOut, 32'h01234567);
`ifdef LOADER_CHECKSUM_EN
        put(8'h22, 0);
`endif
        chk("t1_done", done, 1);
        chk("t1_cpu_rst_held", cpu_reset, 1);
        chk("t1_in_ready_done", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        tick();
        chk("t1_cpu_rst_fall", cpu_reset, 0);
        chk("t1_wcount", wcount, 2);

        // reload, same frame with valid toggling
        do_reload();
        chk("t2_reload_done", done, 0);
        chk("t2_reload_cpu", cpu_reset, 1);
        chk("t2_reload_rdy", bus.in_ready, 1);
        clr_log();
        put(8'h00, 1);
        put(8'h02, 1);
        put(8'hDE, 1);
        put(8'hAD, 1);
        put(8'hBE, 1);
        put(8'hEF, 1);
        put(8'h01, 1);
        put(8'h23, 1);
        put(8'h45, 1);
        put(8'h67, 1);
`ifdef LOADER_CHECKSUM_EN
        put(8'h22, 1);
`endif
        chk("t2_done", done, 1);
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("t2_wcount", wcount, 2);
        chk("t2_a0", q_addr[0], 0);
        chk("t2_d0", q_data[0], 32'hDEADBEEF);
        chk("t2_a1", q_addr[1], 1);
        chk("t2_d1", q_data[1], 32'h01234567);
        chk("t2_cpu", cpu_reset, 0);

        // N=4096 fits exactly
        do_reload();
        clr_log();
        put(8'h10, 0);
        put(8'h00, 0);
        chk("t3_max_rdy", bus.in_ready, 1);
        chk("t3_max_err", error, 0);
        reset = 1'b1;
        #2;
        chk("t3_rst_cpu", cpu_reset, 1);
        chk("t3_rst_data", bus.mem_dataOut, 0);
        reset = 1'b0;

        // N=4097 overflows
        put(8'h10, 0);
        put(8'h01, 0);
        chk("t3_err", error, 1);
        chk("t3_err_rdy", bus.in_ready, 0);
        chk("t3_err_cpu", cpu_reset, 1);
        chk("t3_err_done", done, 0);
        put(8'h11, 0);
        put(8'h22, 0);
        put(8'h33, 0);
        put(8'h44, 0);
        bus.in_valid = 1'b0;
        tick();
        chk("t3_err_hold", error, 1);
        chk("t3_err_cpu2", cpu_reset, 1);
        chk("t3_wcount", wcount, 0);

        // empty image
        do_reload();
        chk("t4_reload_err", error, 0);
        chk("t4_reload_rdy", bus.in_ready, 1);
        put(8'h00, 0);
        put(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        put(8'h00, 0);
`endif
        chk("t4_done", done, 1);
        bus.in_valid = 1'b0;
        tick();
        chk("t4_cpu", cpu_reset, 0);
        chk("t4_wcount", wcount, 0);
        do_reload();
        chk("t4_rl_done", done, 0);
        chk("t4_rl_cpu", cpu_reset, 1);
        chk("t4_rl_rdy", bus.in_ready, 1);

        // reset in the middle of a word
        clr_log();
        put(8'h00, 0);
        put(8'h01, 0);
        put(8'h11, 0);
        put(8'h22, 0);
        reset = 1'b1;
        #2;
        chk("t5_rst_rdy", bus.in_ready, 0);
        chk("t5_rst_wen", bus.mem_wEn, 0);
        reset = 1'b0;
        put(8'h00, 0);
        put(8'h01, 0);
        put(8'hAA, 0);
        put(8'hBB, 0);
        put(8'hCC, 0);
        put(8'hDD, 0);
        chk("t5_wen", bus.mem_wEn, 1);
        chk("t5_addr", bus.mem_addr, 0);
        chk("t5_data", bus.mem_dataOut, 32'hAABBCCDD);
`ifdef LOADER_CHECKSUM_EN
        put(8'h00, 0);
`endif
        chk("t5_done", done, 1);
        bus.in_valid = 1'b0;
        tick();
        chk("t5_wcount", wcount, 1);

`ifdef LOADER_CHECKSUM_EN
        // checksum good and bad
        do_reload();
        clr_log();
        put(8'h00, 0);
        put(8'h01, 0);
        put(8'h11, 0);
        put(8'h22, 0);
        put(8'h33, 0);
        put(8'h44, 0);
        chk("t6_in_csum", done, 0);
        put(8'h44, 0);
        chk("t6_good_done", done, 1);
        chk("t6_good_err", error, 0);
        do_reload();
        put(8'h00, 0);
        put(8'h01, 0);
        put(8'h11, 0);
        put(8'h22, 0);
        put(8'h33, 0);
        put(8'h44, 0);
        put(8'h45, 0);
        chk("t6_bad_err", error, 1);
        chk("t6_bad_done", done, 0);
        bus.in_valid = 1'b0;
        tick();
        chk("t6_bad_cpu", cpu_reset, 1);
        chk("t6_wcount", wcount, 2);
        chk("t6_a", q_addr[1], 0);
        chk("t6_d", q_data[1], 32'h11223344);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the instruction/data memories that the processor only reads.
- Accepts a framed byte stream (from a UART receiver or testbench) and writes 32-bit words into a memory write port.
- Holds the processor in reset (cpu_reset) until the image is fully written.
- Sits between the serial front end and the ROM/RAM write port, beside the processor.

Parameters:
- ADDR_W, 12, memory word-address width (matches the 12-bit imem/dmem addresses).
- BASE_ADDR, 0, word address of the first written word.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge.
- reload  in  1  single-cycle request to restart loading; honoured only in DONE or ERR.
- mem_wEn  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_dataOut  out  32  word to write.
- cpu_reset  out  1  processor reset; high while loading.
- done  out  1  image loaded successfully.
- error  out  1  framing/size/checksum error.

Behaviour:
- Reset values (asynchronous):
  - state = HDR_HI, cpu_reset = 1, done = 0, error = 0.
  - mem_wEn = 0, mem_addr = 0, mem_dataOut = 0.
  - word counter = 0, byte index = 0.
  - in_ready forced 0 while reset is high.
- Frame format:
  - 16-bit word count N, big-endian (HDR_HI byte, then HDR_LO byte).
  - Then N words, each 4 bytes big-endian (first byte → bits 31:24).
  - Optional checksum byte (see Optional Feature).
- in_ready is combinational from state: 1 in HDR_HI, HDR_LO, DATA, CSUM; 0 in DONE and ERR. The loader never stalls the stream mid-frame.
- States:
  - HDR_HI: on accept, latch count[15:8] → HDR_LO.
  - HDR_LO: on accept, latch count[7:0], then:
    - if N > 2^ADDR_W − BASE_ADDR → ERR;
    - else if N == 0 → DONE (or CSUM if the feature is enabled);
    - else → DATA.
  - DATA: shift accepted bytes into a 32-bit assembly register; byte index counts 0..3. On the edge accepting byte 3:
    - mem_wEn = 1 for exactly that next cycle.
    - mem_addr = BASE_ADDR + word counter.
    - mem_dataOut = assembled word.
    - Word counter increments. If the counter reaches N → DONE (CSUM if enabled).
  - DONE: done = 1. cpu_reset deasserts on the edge after DONE is entered, so the final write completes before the processor runs.
  - ERR: error = 1, cpu_reset stays 1, no further writes.
- Latency:
  - Write strobe 1 cycle after the 4th byte handshake.
  - cpu_reset falls 2 edges after the final accepted byte.
- mem_wEn defaults to 0 every cycle unless set as above. mem_addr and mem_dataOut hold their last values.
- reload (in DONE or ERR): next state HDR_HI; cpu_reset = 1, done = 0, error = 0, counters cleared. reload in any other state is ignored.
- in_valid while in_ready is 0: byte dropped, no effect.
- Address never wraps: the size check at HDR_LO guarantees BASE_ADDR + N − 1 ≤ 2^ADDR_W − 1.
- Reset mid-frame: everything returns to reset values immediately. Partially assembled words are discarded; no write strobe is emitted.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Running 8-bit XOR of all payload bytes (excluding header), cleared on entering HDR_HI.
  - After the last word (or directly from HDR_LO when N == 0), state CSUM accepts one byte.
  - Byte equal to running XOR → DONE; otherwise → ERR.
  - Words already written stay written.
- Not defined: no CSUM state, no checksum logic; the last word (or N == 0) goes straight to DONE.

Test Plan:
- N=2 stream 00 02 DE AD BE EF 01 23 45 67 (BASE_ADDR=0), in_valid constant → writes 0xDEADBEEF@0 then 0x01234567@1, each a single-cycle mem_wEn; done=1; cpu_reset falls 2 edges after last byte.
- Same stream with in_valid toggling every other cycle → identical writes and addresses; no extra strobes.
- Header 10 01 (N=4097, ADDR_W=12) → ERR after 2nd byte, error=1, in_ready=0, no mem_wEn, cpu_reset stays 1.
- Header 00 00 → DONE immediately, no writes; then pulse reload → done=0, cpu_reset=1, in_ready=1 in HDR_HI.
- Assert reset after 2 of 4 data bytes, release, send 00 01 AA BB CC DD → single write 0xAABBCCDD@0; no write from the aborted word.
- With LOADER_CHECKSUM_EN: 00 01 11 22 33 44 plus checksum 44 → DONE; same frame with checksum 45 → ERR, word still written at 0.
